// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one external Booth multiplier among NUM_REQ requesters.
// One operation in flight; the result is held on rsp_* until the consumer accepts it.
module booth_mult_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_id,
  output logic [2*WIDTH-1:0]         rsp_p,
  input  logic                       rsp_ready,
  output logic                       mul_start,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_p,
  input  logic                       mul_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [1:0] last_grant;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic       gnt_found;

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = 2'((int'(last_grant) + k) % int'(NUM_REQ));
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // req_ready and mul_start are both visible during the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'(NUM_REQ - 1);
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_p      <= '0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      req_ready <= '0;
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            req_ready  <= NUM_REQ'(1) << gnt_idx;
            mul_start  <= 1'b1;
            mul_a      <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
            mul_b      <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
            last_grant <= gnt_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mul_done) begin
            rsp_p     <= mul_p;
            rsp_id    <= last_grant;
            rsp_valid <= 1'b1;
            mul_a     <= '0;
            mul_b     <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mult_arbiter.md
BOOTH_MULT_ARBITER -- requirements
Module: booth_mult_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4: number of requesters, fixed at 4 for this revision.
REQ-002 SHALL provide parameter WIDTH, default 16: operand width, product width 2*WIDTH.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_a  input  NUM_REQ*WIDTH  packed multiplicands; slice i = bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NUM_REQ*WIDTH  packed multipliers; same packing as req_a.
REQ-009 req_ready  output  NUM_REQ  one-hot accept pulse to the granted requester.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_id  output  2  index of the requester owning the result.
REQ-012 rsp_p  output  2*WIDTH  signed product.
REQ-013 rsp_ready  input  1  consumer accepts the result.
REQ-014 mul_start  output  1  start pulse to the shared Booth multiplier.
REQ-015 mul_a, mul_b  output  WIDTH each  operands to the multiplier.
REQ-016 mul_p  input  2*WIDTH  multiplier product, valid while mul_done=1.
REQ-017 mul_done  input  1  one-cycle completion pulse from the multiplier.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, RESP, with all outputs registered.
REQ-019 IDLE, any req_valid=1: SHALL grant one requester by round-robin, searching from last_grant+1 modulo NUM_REQ.
REQ-020 Grant cycle: SHALL pulse req_ready[g] for exactly one cycle, latch req_a/req_b slice g and id g, update last_grant=g, and go to ISSUE.
REQ-021 Transaction completes when req_valid[g] and req_ready[g] are both 1 in the same cycle; req_valid need not drop afterwards.
REQ-022 ISSUE: SHALL drive mul_start=1 for exactly one cycle with latched operands on mul_a/mul_b, then go to WAIT.
REQ-023 mul_a/mul_b SHALL hold the latched operands from ISSUE until leaving WAIT.
REQ-024 WAIT: on mul_done=1, SHALL capture mul_p into the result register and go to RESP; no timeout.
REQ-025 mul_done seen in any state other than WAIT SHALL be ignored.
REQ-026 RESP: SHALL hold rsp_valid=1 with stable rsp_id/rsp_p until rsp_ready=1, then go to IDLE next cycle.
REQ-027 rsp_valid and req_ready SHALL never be high in the same cycle; at most one operation in flight.
REQ-028 rsp_ready sampled high while a new req_valid is pending: grant SHALL occur in the following IDLE cycle.
REQ-029 Minimum throughput: grant-to-grant interval = 1 (IDLE) + 1 (ISSUE) + multiplier latency + RESP cycles.
REQ-030 Product SHALL be passed through unmodified as signed two's-complement 2*WIDTH bits.
REQ-031 Requesters that drop req_valid before a grant SHALL be skipped with no state change.

Reset
REQ-032 On rst=1, asynchronously: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, mul_start=0, mul_a=0, mul_b=0.
REQ-033 Reset mid-operation SHALL discard the in-flight operation without a response.
REQ-034 The system SHALL reset the multiplier together with the arbiter (rst_n = ~rst).
REQ-035 A stale mul_done after reset SHALL be ignored per REQ-025.

Verification
REQ-036 req_valid=0001, a=3, b=5 -> req_ready=0001 one cycle, mul_start one pulse, then rsp_valid with rsp_id=0, rsp_p=0x0000000F.
REQ-037 Requester 2 sends a=0xFFFE (-2), b=7 -> rsp_id=2, rsp_p=0xFFFFFFF2.
REQ-038 After reset, req_valid=1111 held with rsp_ready=1 -> grant order 0,1,2,3,0, each grant exactly one pulse.
REQ-039 last_grant=1, req_valid=0101 -> grant 2, then 0.
REQ-040 RESP with rsp_ready=0 for 10 cycles -> rsp_valid/rsp_id/rsp_p stable, no req_ready, no mul_start; rsp_ready=1 -> IDLE next cycle.
REQ-041 rst=1 during WAIT -> all outputs 0 immediately; a mul_done pulse afterwards produces no rsp_valid.
